demultiplexer_stream: RTL and testbench
=======================================

DEMULTIPLEXER_STREAM -- requirements
Module: demultiplexer_stream

Interface
REQ-001 Parameter: WIDTH, 64, data width of the input and both outputs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 selector  input  1  routing select: 1 routes to output a, 0 routes to output b.
REQ-005 in_data  input  WIDTH  input word.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 a  output  WIDTH  registered output word, port a.
REQ-009 a_valid  output  1  a holds an undelivered word.
REQ-010 a_ready  input  1  consumer of a accepts this cycle.
REQ-011 b  output  WIDTH  registered output word, port b.
REQ-012 b_valid  output  1  b holds an undelivered word.
REQ-013 b_ready  input  1  consumer of b accepts this cycle.

Function
REQ-014 Each output has one holding register with a two-state FSM: EMPTY (valid=0) and FULL (valid=1).
REQ-015 Input transfer occurs when in_valid && in_ready at a rising edge; output transfer occurs when x_valid && x_ready.
REQ-016 in_ready is combinational: if selector=1, it is (!a_valid || a_ready); if selector=0, it is (!b_valid || b_ready).
REQ-017 selector is sampled only in the input-transfer cycle; the word is loaded into the selected register, and its valid is set at the next edge (latency 1 cycle).
REQ-018 FSM transitions are as follows: EMPTY->FULL on an input transfer to that port; FULL->EMPTY on an output transfer with no simultaneous input to that port; FULL->FULL with new data when an output transfer and an input transfer to the same port coincide.
REQ-019 The unselected port is never written; it holds its data and drains independently of the input side.
REQ-020 Both ports may drain in the same cycle in which the input loads one of them.
REQ-021 A FULL port's data and valid are stable until its output transfer; there are no drops and no duplicates.
REQ-022 Word order is preserved per port; no ordering is guaranteed across ports.
REQ-023 Sustained throughput is 1 word/cycle while the selected consumer holds ready=1.
REQ-024 A change of selector while in_valid=1 and in_ready=0 is legal; in_ready re-evaluates against the newly selected port.

Reset
REQ-025 While reset=1 at a rising edge: a_valid=0, b_valid=0, a=0, b=0, and counters (if present) are 0.
REQ-026 Reset during operation discards held words with no output transfer; in_ready is then 1 from the first cycle after reset.
REQ-027 Inputs are ignored while reset=1, and in_ready is driven 0 during reset.

Configuration
REQ-028 Macro DEMUX_XFER_COUNT_EN, when defined, adds outputs a_count and b_count (16 bits each); each counts that port's output transfers.
REQ-029 With DEMUX_XFER_COUNT_EN, counters wrap 16'hFFFF->0 with no saturation or flag.
REQ-030 Without DEMUX_XFER_COUNT_EN, the count ports and logic are absent and all other behaviour is identical.

Verification
REQ-031 Scenario: reset 2 cycles; selector=1, in_data=64'h1, in_valid=1 one cycle, a_ready=0 -> next cycle a=64'h1, a_valid=1, b_valid=0.
REQ-032 Scenario: with a FULL and a_ready=0, selector=1, in_valid=1 -> in_ready=0; a holds 64'h1; then a_ready=1 -> same cycle in_ready=1 and the new word replaces a at that edge.
REQ-033 Scenario: a FULL with a_ready=0; selector=0, in_data=64'h0, in_valid=1 -> in_ready=1; next cycle b=0, b_valid=1, and a is unchanged.
REQ-034 Scenario: alternate selector 1/0 every cycle, in_data incrementing from 1, both ready=1 for 10 cycles -> a receives 1,3,5,7,9; b receives 2,4,6,8,10; no stalls.
REQ-035 Scenario: a and b FULL, assert reset for one cycle -> both valid=0 next cycle, no output transfers, and in_ready=1 afterward.
REQ-036 Scenario with DEMUX_XFER_COUNT_EN: 65537 transfers on port b -> b_count=1 and a_count=0.

Source files
------------

// File: rtl/demultiplexer_stream.sv
// ============================================================================
// demultiplexer_stream
// ----------------------------------------------------------------------------
// Routes a valid/ready input stream to one of two registered output ports.
// Each output port owns a single holding register governed by a two-state
// EMPTY/FULL machine. The selector is only looked at in the cycle an input
// word is actually accepted; the word lands in the chosen register and its
// valid rises one clock later. The port that is not selected keeps its word
// and drains on its own schedule, so both ports can drain in the same cycle
// that one of them is being reloaded.
//
// Optional feature (macro DEMUX_XFER_COUNT_EN):
//   When defined, two 16-bit free-running output-transfer counters are
//   added (a_count, b_count). They wrap from 16'hFFFF to 0 silently.
//   When undefined, the counters and their ports do not exist.
//
// Parameters:
//   WIDTH      data width of in_data, a and b (default 64)
//
// Ports:
//   clk        single clock, rising-edge active
//   reset      synchronous, active-high reset
//   selector   1 routes the accepted word to port a, 0 routes it to port b
//   in_data    input word
//   in_valid   in_data is valid this cycle
//   in_ready   block accepts in_data this cycle (combinational, 0 in reset)
//   a          registered output word, port a
//   a_valid    port a holds an undelivered word
//   a_ready    consumer of port a accepts this cycle
//   b          registered output word, port b
//   b_valid    port b holds an undelivered word
//   b_ready    consumer of port b accepts this cycle
//   a_count    (DEMUX_XFER_COUNT_EN only) port a output transfers, mod 2^16
//   b_count    (DEMUX_XFER_COUNT_EN only) port b output transfers, mod 2^16
// ============================================================================
module demultiplexer_stream #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             selector,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX_XFER_COUNT_EN
    ,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
`endif
);

    // ------------------------------------------------------------------------
    // Per-port holding-register state
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } port_state_t;

    port_state_t      a_state_r;
    port_state_t      a_state_next_s;
    port_state_t      b_state_r;
    port_state_t      b_state_next_s;

    logic [WIDTH-1:0] a_data_r;
    logic [WIDTH-1:0] b_data_r;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic             a_full_s;
    logic             b_full_s;
    logic             a_space_s;
    logic             b_space_s;
    logic             in_ready_s;
    logic             in_xfer_s;
    logic             a_load_s;
    logic             b_load_s;
    logic             a_drain_s;
    logic             b_drain_s;

    // Decode occupancy, space and transfer strobes for both ports.
    always_comb begin
        a_full_s  = (a_state_r == ST_FULL);
        b_full_s  = (b_state_r == ST_FULL);

        // A port can take a word if it is empty, or if its current word is
        // leaving in this very cycle (gives back-to-back throughput).
        a_space_s = (!a_full_s) || a_ready;
        b_space_s = (!b_full_s) || b_ready;

        // in_ready only looks at the currently selected port, so a selector
        // change while stalled immediately re-evaluates against the new port.
        if (reset) begin
            in_ready_s = 1'b0;
        end else if (selector) begin
            in_ready_s = a_space_s;
        end else begin
            in_ready_s = b_space_s;
        end

        in_xfer_s = in_valid && in_ready_s;

        // Selector matters only on the cycle a word is actually accepted.
        a_load_s  = in_xfer_s && selector;
        b_load_s  = in_xfer_s && !selector;

        // Output transfers are gated by reset so a reset cycle never counts
        // as a delivery of the held word.
        a_drain_s = a_full_s && a_ready && !reset;
        b_drain_s = b_full_s && b_ready && !reset;
    end

    // ------------------------------------------------------------------------
    // Port a next-state
    // ------------------------------------------------------------------------
    // Next-state logic for the port a holding register.
    always_comb begin
        a_state_next_s = a_state_r;
        case (a_state_r)
            ST_EMPTY: begin
                if (a_load_s) begin
                    a_state_next_s = ST_FULL;
                end else begin
                    a_state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // A drain coinciding with a load keeps the port FULL with the
                // new word; a drain alone empties it.
                if (a_drain_s && !a_load_s) begin
                    a_state_next_s = ST_EMPTY;
                end else begin
                    a_state_next_s = ST_FULL;
                end
            end
            default: begin
                a_state_next_s = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Port b next-state
    // ------------------------------------------------------------------------
    // Next-state logic for the port b holding register.
    always_comb begin
        b_state_next_s = b_state_r;
        case (b_state_r)
            ST_EMPTY: begin
                if (b_load_s) begin
                    b_state_next_s = ST_FULL;
                end else begin
                    b_state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (b_drain_s && !b_load_s) begin
                    b_state_next_s = ST_EMPTY;
                end else begin
                    b_state_next_s = ST_FULL;
                end
            end
            default: begin
                b_state_next_s = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------------
    // Port a state register and data holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_state_r <= ST_EMPTY;
            a_data_r  <= {WIDTH{1'b0}};
        end else begin
            a_state_r <= a_state_next_s;
            // Data changes only on a load; a drained word stays visible.
            if (a_load_s) begin
                a_data_r <= in_data;
            end else begin
                a_data_r <= a_data_r;
            end
        end
    end

    // Port b state register and data holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_state_r <= ST_EMPTY;
            b_data_r  <= {WIDTH{1'b0}};
        end else begin
            b_state_r <= b_state_next_s;
            if (b_load_s) begin
                b_data_r <= in_data;
            end else begin
                b_data_r <= b_data_r;
            end
        end
    end

`ifdef DEMUX_XFER_COUNT_EN
    // ------------------------------------------------------------------------
    // Output-transfer counters (wrap silently at 16 bits)
    // ------------------------------------------------------------------------
    logic [15:0] a_count_r;
    logic [15:0] b_count_r;

    // Count delivered words on each port.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_count_r <= 16'd0;
            b_count_r <= 16'd0;
        end else begin
            if (a_drain_s) begin
                a_count_r <= a_count_r + 16'd1;
            end else begin
                a_count_r <= a_count_r;
            end
            if (b_drain_s) begin
                b_count_r <= b_count_r + 16'd1;
            end else begin
                b_count_r <= b_count_r;
            end
        end
    end

    assign a_count = a_count_r;
    assign b_count = b_count_r;
`else
    // Counters are not built in this configuration.
`endif

    // ------------------------------------------------------------------------
    // Output drive: data and valid come straight from registers
    // ------------------------------------------------------------------------
    assign a        = a_data_r;
    assign a_valid  = (a_state_r == ST_FULL);
    assign b        = b_data_r;
    assign b_valid  = (b_state_r == ST_FULL);
    assign in_ready = in_ready_s;

endmodule

// File: tb/tb_demultiplexer_stream.sv
// ============================================================================
// tb_demultiplexer_stream
// ----------------------------------------------------------------------------
// Self-checking bench for demultiplexer_stream. A behavioural model treats
// each output port as a one-entry buffer (full flag + held word) and derives
// the expected in_ready, valids, data and transfer counts from the routing
// rules. Directed scenarios with literal expectations pin the model; a long
// randomized phase is then checked against it on every cycle.
// ============================================================================
module tb_demultiplexer_stream;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             selector;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b;
    logic             b_valid;
    logic             b_ready;
`ifdef DEMUX_XFER_COUNT_EN
    logic [15:0]      a_count;
    logic [15:0]      b_count;
`endif

    demultiplexer_stream #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .selector (selector),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b        (b),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX_XFER_COUNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Behavioural model: one-entry buffer per port.
    logic             m_a_full;
    logic             m_b_full;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    int               m_a_cnt;
    int               m_b_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check in_ready against the model, predict the
    // transfers of this edge, advance, then check all registered outputs.
    task automatic step();
        logic exp_rdy;
        logic ix;
        logic ax;
        logic bx;
        #1;
        if (reset)
            exp_rdy = 1'b0;
        else if (selector)
            exp_rdy = !m_a_full || a_ready;
        else
            exp_rdy = !m_b_full || b_ready;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        ix = in_valid && exp_rdy;
        ax = m_a_full && a_ready && !reset;
        bx = m_b_full && b_ready && !reset;
        @(posedge clk);
        #1;
        if (reset) begin
            m_a_full = 1'b0;
            m_b_full = 1'b0;
            m_a      = '0;
            m_b      = '0;
            m_a_cnt  = 0;
            m_b_cnt  = 0;
        end else begin
            if (ax) begin
                m_a_full = 1'b0;
                m_a_cnt  = (m_a_cnt + 1) % 65536;
            end
            if (bx) begin
                m_b_full = 1'b0;
                m_b_cnt  = (m_b_cnt + 1) % 65536;
            end
            if (ix) begin
                if (selector) begin
                    m_a_full = 1'b1;
                    m_a      = in_data;
                end else begin
                    m_b_full = 1'b1;
                    m_b      = in_data;
                end
            end
        end
        chk("a_valid", {63'd0, a_valid}, {63'd0, m_a_full});
        chk("b_valid", {63'd0, b_valid}, {63'd0, m_b_full});
        chk("a_data", a, m_a);
        chk("b_data", b, m_b);
`ifdef DEMUX_XFER_COUNT_EN
        chk("a_count", {48'd0, a_count}, 64'(m_a_cnt));
        chk("b_count", {48'd0, b_count}, 64'(m_b_cnt));
`endif
    endtask

    task automatic drive(input logic rst, input logic sel, input logic [63:0] d,
                         input logic v, input logic ar, input logic br);
        reset    = rst;
        selector = sel;
        in_data  = d;
        in_valid = v;
        a_ready  = ar;
        b_ready  = br;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        m_a_full = 1'b0;
        m_b_full = 1'b0;
        m_a      = '0;
        m_b      = '0;
        m_a_cnt  = 0;
        m_b_cnt  = 0;

        // Reset for two cycles; inputs ignored meanwhile.
        drive(1'b1, 1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("rst_a", a, 64'h0);
        chk("rst_b", b, 64'h0);
        chk("rst_a_valid", {63'd0, a_valid}, 64'h0);

        // Single word to a, a consumer stalled.
        drive(1'b0, 1'b1, 64'h1, 1'b1, 1'b0, 1'b0);
        #1 chk("first_in_ready", {63'd0, in_ready}, 64'h1);
        step();
        chk("s1_a", a, 64'h1);
        chk("s1_a_valid", {63'd0, a_valid}, 64'h1);
        chk("s1_b_valid", {63'd0, b_valid}, 64'h0);

        // a FULL and stalled: input to a must stall, a holds.
        drive(1'b0, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0);
        #1 chk("s2_stall", {63'd0, in_ready}, 64'h0);
        step();
        chk("s2_hold", a, 64'h1);
        // Consumer ready: pass-through replacement in the same edge.
        drive(1'b0, 1'b1, 64'h2, 1'b1, 1'b1, 1'b0);
        #1 chk("s2_ready", {63'd0, in_ready}, 64'h1);
        step();
        chk("s2_replace", a, 64'h2);
        chk("s2_a_valid", {63'd0, a_valid}, 64'h1);

        // a FULL and stalled; routing to b is unaffected.
        drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        #1 chk("s3_ready", {63'd0, in_ready}, 64'h1);
        step();
        chk("s3_b", b, 64'h0);
        chk("s3_b_valid", {63'd0, b_valid}, 64'h1);
        chk("s3_a_kept", a, 64'h2);

        // Drain both.
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        step();

        // Alternating selector at full rate, both consumers ready.
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, (i % 2) == 1, 64'(i), 1'b1, 1'b1, 1'b1);
            #1 chk("alt_no_stall", {63'd0, in_ready}, 64'h1);
            step();
            if ((i % 2) == 1)
                chk("alt_a", a, 64'(i));
            else
                chk("alt_b", b, 64'(i));
        end

        // Fill both, then reset one cycle with consumers stalled.
        drive(1'b0, 1'b1, 64'hAA, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 64'hBB, 1'b1, 1'b0, 1'b0);
        step();
        chk("s5_both_full", {62'd0, a_valid, b_valid}, 64'h3);
        drive(1'b1, 1'b0, 64'hCC, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 64'hCC, 1'b0, 1'b0, 1'b0);
        #1 chk("s5_ready_after", {63'd0, in_ready}, 64'h1);
        chk("s5_valids", {62'd0, a_valid, b_valid}, 64'h0);
        step();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  1'($urandom_range(0, 1)),
                  {$urandom(), $urandom()},
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) != 0);
            step();
        end

`ifdef DEMUX_XFER_COUNT_EN
        // 65537 transfers on b: counter wraps to 1, a untouched.
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 65538; i++) begin
            drive(1'b0, 1'b0, 64'(i), 1'b1, 1'b0, 1'b1);
            step();
        end
        chk("cnt_b_wrap", {48'd0, b_count}, 64'h1);
        chk("cnt_a_zero", {48'd0, a_count}, 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
